set_coverage_counter: RTL

Parametrised grid-coverage counter for the SOC set-evaluation path. It loads NSET circles (centre plus radius) in one request and scans every lattice point of a GRID×GRID grid, one point per clock. It counts the points that satisfy a selectable set-combination mode and returns the count through a busy/valid handshake. It replaces the fixed 8×8, three-circle, four-mode evaluator with configurable size, channel count and threshold modes.

---
 rtl/set_coverage_counter_if.sv | 22 ++
 rtl/set_coverage_counter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/set_coverage_counter_if.sv
// Request/result bundle for the grid-coverage counter: circle operands in,
// busy/valid/candidate out.
interface set_coverage_counter_if #(
  parameter int unsigned NSET = 3,
  parameter int unsigned CW   = 4,
  parameter int unsigned CNTW = 8,
  parameter int unsigned KW   = 2
);
  logic                     en;
  logic [2*CW*NSET-1:0]     central;
  logic [CW*NSET-1:0]       radius;
  logic [2:0]               mode;
  logic [KW-1:0]            thr;
  logic                     busy;
  logic                     valid;
  logic [CNTW-1:0]          candidate;

  modport master (output en, central, radius, mode, thr,
                  input  busy, valid, candidate);
  modport slave  (input  en, central, radius, mode, thr,
                  output busy, valid, candidate);
endinterface

// File: rtl/set_coverage_counter.sv
// Scans every lattice point of a GRID x GRID grid, one per clock, and counts
// the points whose circle-membership pattern satisfies the selected mode.
module set_coverage_counter #(
  parameter int unsigned GRID = 8,
  parameter int unsigned NSET = 3,
  parameter int unsigned CW   = 4,
  parameter int unsigned CNTW = 8,
  parameter int unsigned KW   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  set_coverage_counter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        px, py;
  logic [2*CW*NSET-1:0] central_q;
  logic [CW*NSET-1:0]   radius_q;
  logic [2:0]           mode_q;
  logic [KW-1:0]        thr_q;
  logic                 hit_q, hit_vld;
  logic                 busy, valid;
  logic [CNTW-1:0]      candidate;

  logic [NSET-1:0]      m;
  logic [KW-1:0]        c;
  logic                 hit_c;

  assign bus.busy      = busy;
  assign bus.valid     = valid;
  assign bus.candidate = candidate;

  // Exact squared distance: |dx|,|dy| fit CW bits, squares summed at 2*CW+1 bits.
  function automatic logic in_circle(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                     input logic [CW-1:0] cx, input logic [CW-1:0] cy,
                                     input logic [CW-1:0] r);
    logic [CW-1:0]   ax, ay;
    logic [2*CW:0]   d2, r2;
    ax = (x >= cx) ? x - cx : cx - x;
    ay = (y >= cy) ? y - cy : cy - y;
    d2 = (2*CW+1)'(ax) * (2*CW+1)'(ax) + (2*CW+1)'(ay) * (2*CW+1)'(ay);
    r2 = (2*CW+1)'(r) * (2*CW+1)'(r);
    return d2 <= r2;
  endfunction

  always_comb begin
    m     = '0;
    c     = '0;
    hit_c = 1'b0;
    for (int i = 0; i < NSET; i++) begin
      m[i] = in_circle(px, py,
                       central_q[2*CW*(NSET-i)-1 -: CW],
                       central_q[2*CW*(NSET-i)-CW-1 -: CW],
                       radius_q[CW*(NSET-i)-1 -: CW]);
      c = c + KW'(m[i]);
    end
    case (mode_q)
      3'b000:  hit_c = m[0];
      3'b001:  hit_c = m[0] & m[1];
      3'b010:  hit_c = m[0] ^ m[1];
      3'b011:  hit_c = (c == thr_q);
      3'b100:  hit_c = (c >= thr_q);
      3'b101:  hit_c = |m;
      default: hit_c = 1'b0;
    endcase
  end

  // Membership is registered one cycle ahead of accumulation; FLUSH drains it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      px        <= CW'(1);
      py        <= CW'(1);
      central_q <= '0;
      radius_q  <= '0;
      mode_q    <= '0;
      thr_q     <= '0;
      hit_q     <= 1'b0;
      hit_vld   <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      candidate <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.en) begin
            central_q <= bus.central;
            radius_q  <= bus.radius;
            mode_q    <= bus.mode;
            thr_q     <= bus.thr;
            candidate <= '0;
            px        <= CW'(1);
            py        <= CW'(1);
            hit_vld   <= 1'b0;
            busy      <= 1'b1;
            state     <= SCAN;
          end else begin
            state <= IDLE;
          end
        end
        SCAN: begin
          hit_q   <= hit_c;
          hit_vld <= 1'b1;
          if (hit_vld && hit_q) candidate <= candidate + CNTW'(1);
          if (px == CW'(GRID)) begin
            px <= CW'(1);
            if (py == CW'(GRID)) begin
              py    <= CW'(1);
              state <= FLUSH;
            end else begin
              py <= py + CW'(1);
            end
          end else begin
            px <= px + CW'(1);
          end
        end
        FLUSH: begin
          if (hit_vld) begin
            if (hit_q) candidate <= candidate + CNTW'(1);
            hit_vld <= 1'b0;
          end else begin
            busy  <= 1'b0;
            valid <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
